// File: rtl/bmain_arb_if.sv
// Bus bundle for bmain_arb: N requester-side channels (m_*) plus the single
// downstream master port (s_*) and the grant vector.
//
// Modports:
//   master - the arbiter's view: it serves the m_* requesters and drives the
//            downstream s_* master port.
//   slave  - the environment's view: requesters plus downstream target.
//
// m_addr packs word address [28:2] per requester, slice i = bits 27i+26:27i.
// m_wdata / m_wmask pack 32 / 4 bits per requester the same way.
interface bmain_arb_if #(
  parameter int unsigned N = 2
) ();

  // Requester side
  logic [N-1:0]    m_cvalid;
  logic [N-1:0]    m_cready;
  logic [N-1:0]    m_cmd;
  logic [27*N-1:0] m_addr;
  logic [N-1:0]    m_lock;
  logic [N-1:0]    m_wvalid;
  logic [N-1:0]    m_wlast;
  logic [32*N-1:0] m_wdata;
  logic [4*N-1:0]  m_wmask;
  logic [N-1:0]    m_wready;
  logic [N-1:0]    m_rvalid;
  logic [N-1:0]    m_rready;
  logic            m_rlast;
  logic [31:0]     m_rdata;
  logic [N-1:0]    m_error;
  logic [N-1:0]    m_eack;

  // Downstream side
  logic            s_cvalid;
  logic            s_cready;
  logic            s_cmd;
  logic [26:0]     s_addr;
  logic            s_wvalid;
  logic            s_wready;
  logic            s_wlast;
  logic [31:0]     s_wdata;
  logic [3:0]      s_wmask;
  logic            s_rvalid;
  logic            s_rready;
  logic            s_rlast;
  logic [31:0]     s_rdata;
  logic            s_error;
  logic            s_eack;

  logic [N-1:0]    gnt;

  modport master (
    input  m_cvalid, m_cmd, m_addr, m_lock, m_wvalid, m_wlast, m_wdata, m_wmask,
    input  m_rready, m_eack,
    output m_cready, m_wready, m_rvalid, m_rlast, m_rdata, m_error,
    output s_cvalid, s_cmd, s_addr, s_wvalid, s_wlast, s_wdata, s_wmask,
    output s_rready, s_eack, gnt,
    input  s_cready, s_wready, s_rvalid, s_rlast, s_rdata, s_error
  );

  modport slave (
    output m_cvalid, m_cmd, m_addr, m_lock, m_wvalid, m_wlast, m_wdata, m_wmask,
    output m_rready, m_eack,
    input  m_cready, m_wready, m_rvalid, m_rlast, m_rdata, m_error,
    input  s_cvalid, s_cmd, s_addr, s_wvalid, s_wlast, s_wdata, s_wmask,
    input  s_rready, s_eack, gnt,
    output s_cready, s_wready, s_rvalid, s_rlast, s_rdata, s_error
  );

endinterface

// File: rtl/bmain_arb.sv
// Round-robin arbiter in front of the main system bus master port.
// N requesters share one command / write / read / error channel set. A grant
// is held for the whole transaction (command beat through last data beat or
// error acknowledge). m_lock lets the owner keep the grant for up to LOCK_MAX
// consecutive commands, for atomic read-modify-write.
//
// Ports:
//   clk_core - core clock
//   reset_n  - synchronous active-low reset
//   bus      - bmain_arb_if master modport (requesters, downstream port, gnt)
//
// All ready/valid paths are combinational pass-throughs selected by the
// current owner; no data is buffered here.
module bmain_arb #(
  parameter int unsigned N        = 2,
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic        clk_core,
  input  logic        reset_n,
  bmain_arb_if.master bus
);

  localparam int unsigned IdxW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData
  } state_e;

  // (base + k) mod N, for k in 0..N-1 and base in 0..N-1
  function automatic logic [IdxW-1:0] wrap_inc(logic [IdxW-1:0] base, int unsigned k);
    logic [IdxW:0] sum;
    sum = {1'b0, base} + (IdxW+1)'(k);
    if (sum >= (IdxW+1)'(N)) begin
      sum = sum - (IdxW+1)'(N);
    end
    return sum[IdxW-1:0];
  endfunction

  state_e          state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [3:0]      lock_cnt_q, lock_cnt_d;
  logic            is_read_q, is_read_d;

  // Round-robin winner search
  logic [IdxW-1:0] winner;
  logic [IdxW-1:0] cand;
  logic            found;

  always_comb begin
    winner = ptr_q;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = wrap_inc(ptr_q, k);
      if (!found && bus.m_cvalid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Owner-selected views of the requester inputs
  logic [N-1:0] owner_oh;
  logic         own_cvalid;
  logic         own_cmd;
  logic [26:0]  own_addr;
  logic         own_lock;
  logic         own_wvalid;
  logic         own_wlast;
  logic [31:0]  own_wdata;
  logic [3:0]   own_wmask;
  logic         own_rready;
  logic         own_eack;

  always_comb begin
    owner_oh   = '0;
    own_cvalid = 1'b0;
    own_cmd    = 1'b0;
    own_addr   = '0;
    own_lock   = 1'b0;
    own_wvalid = 1'b0;
    own_wlast  = 1'b0;
    own_wdata  = '0;
    own_wmask  = '0;
    own_rready = 1'b0;
    own_eack   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (owner_q == IdxW'(i)) begin
        owner_oh[i] = 1'b1;
        own_cvalid  = bus.m_cvalid[i];
        own_cmd     = bus.m_cmd[i];
        own_addr    = bus.m_addr[27*i +: 27];
        own_lock    = bus.m_lock[i];
        own_wvalid  = bus.m_wvalid[i];
        own_wlast   = bus.m_wlast[i];
        own_wdata   = bus.m_wdata[32*i +: 32];
        own_wmask   = bus.m_wmask[4*i +: 4];
        own_rready  = bus.m_rready[i];
        own_eack    = bus.m_eack[i];
      end
    end
  end

  // Outputs, driven from the FSM below
  logic [N-1:0] m_cready;
  logic [N-1:0] m_wready;
  logic [N-1:0] m_rvalid;
  logic         m_rlast;
  logic [31:0]  m_rdata;
  logic [N-1:0] m_error;
  logic         s_cvalid;
  logic         s_cmd;
  logic [26:0]  s_addr;
  logic         s_wvalid;
  logic         s_wlast;
  logic [31:0]  s_wdata;
  logic [3:0]   s_wmask;
  logic         s_rready;
  logic         s_eack;
  logic [N-1:0] gnt;

  logic err_done;
  logic beat_done;
  logic lock_more;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    lock_cnt_d = lock_cnt_q;
    is_read_d  = is_read_q;

    m_cready   = '0;
    m_wready   = '0;
    m_rvalid   = '0;
    m_rlast    = 1'b0;
    m_rdata    = '0;
    m_error    = '0;
    s_cvalid   = 1'b0;
    s_cmd      = 1'b0;
    s_addr     = '0;
    s_wvalid   = 1'b0;
    s_wlast    = 1'b0;
    s_wdata    = '0;
    s_wmask    = '0;
    s_rready   = 1'b0;
    s_eack     = 1'b0;
    gnt        = '0;

    err_done   = 1'b0;
    beat_done  = 1'b0;
    lock_more  = own_lock && ((32'(lock_cnt_q) + 32'd1) < LOCK_MAX);

    unique case (state_q)
      StIdle: begin
        if (|bus.m_cvalid) begin
          owner_d    = winner;
          ptr_d      = wrap_inc(winner, 1);
          lock_cnt_d = '0;
          state_d    = StCmd;
        end
      end

      StCmd: begin
        gnt      = owner_oh;
        s_cvalid = own_cvalid;
        s_cmd    = own_cmd;
        s_addr   = own_addr;
        m_cready = owner_oh & {N{bus.s_cready}};
        m_error  = owner_oh & {N{bus.s_error}};
        s_eack   = own_eack;
        err_done = bus.s_error && own_eack;
        if (err_done) begin
          state_d = StIdle;
        end else if (!own_cvalid) begin
          // Locked owner without a follow-up command releases the bus
          state_d = StIdle;
        end else if (bus.s_cready) begin
          is_read_d = own_cmd;
          state_d   = StData;
        end
      end

      StData: begin
        gnt      = owner_oh;
        m_error  = owner_oh & {N{bus.s_error}};
        s_eack   = own_eack;
        err_done = bus.s_error && own_eack;
        if (is_read_q) begin
          m_rvalid  = owner_oh & {N{bus.s_rvalid}};
          s_rready  = own_rready;
          m_rlast   = bus.s_rlast;
          m_rdata   = bus.s_rdata;
          beat_done = bus.s_rvalid && own_rready && bus.s_rlast;
        end else begin
          s_wvalid  = own_wvalid;
          s_wlast   = own_wlast;
          s_wdata   = own_wdata;
          s_wmask   = own_wmask;
          m_wready  = owner_oh & {N{bus.s_wready}};
          beat_done = own_wvalid && bus.s_wready && own_wlast;
        end
        if (err_done) begin
          // Errors always release the bus, lock or not
          state_d = StIdle;
        end else if (beat_done) begin
          if (lock_more) begin
            lock_cnt_d = lock_cnt_q + 4'd1;
            state_d    = StCmd;
          end else begin
            state_d = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      ptr_q      <= '0;
      lock_cnt_q <= '0;
      is_read_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      lock_cnt_q <= lock_cnt_d;
      is_read_q  <= is_read_d;
    end
  end

  assign bus.m_cready = m_cready;
  assign bus.m_wready = m_wready;
  assign bus.m_rvalid = m_rvalid;
  assign bus.m_rlast  = m_rlast;
  assign bus.m_rdata  = m_rdata;
  assign bus.m_error  = m_error;
  assign bus.s_cvalid = s_cvalid;
  assign bus.s_cmd    = s_cmd;
  assign bus.s_addr   = s_addr;
  assign bus.s_wvalid = s_wvalid;
  assign bus.s_wlast  = s_wlast;
  assign bus.s_wdata  = s_wdata;
  assign bus.s_wmask  = s_wmask;
  assign bus.s_rready = s_rready;
  assign bus.s_eack   = s_eack;
  assign bus.gnt      = gnt;

  gnt_onehot_a : assert property (@(posedge clk_core) disable iff (!reset_n)
    $onehot0(gnt));

  non_owner_quiet_a : assert property (@(posedge clk_core) disable iff (!reset_n)
    ((m_cready | m_wready | m_rvalid | m_error) & ~gnt) == '0);

  lock_cnt_bound_a : assert property (@(posedge clk_core) disable iff (!reset_n)
    32'(lock_cnt_q) < LOCK_MAX);

endmodule

// File: tb/tb_bmain_arb.sv
module tb_bmain_arb;

  logic clk_core;
  logic reset_n;

  int checks;
  int failures;

  bmain_arb_if #(.N(2)) bus ();

  bmain_arb #(
    .N        (2),
    .LOCK_MAX (2)
  ) dut (
    .clk_core (clk_core),
    .reset_n  (reset_n),
    .bus      (bus.master)
  );

  initial clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  // All handshake outputs that must be low in reset / idle
  logic [13:0] outs;
  assign outs = {bus.gnt, bus.m_cready, bus.m_wready, bus.m_rvalid, bus.m_error,
                 bus.s_cvalid, bus.s_wvalid, bus.s_rready, bus.s_eack};

  task automatic tick();
    @(posedge clk_core);
    #2;
  endtask

  task automatic clear_inputs();
    bus.m_cvalid = '0;
    bus.m_cmd    = '0;
    bus.m_addr   = '0;
    bus.m_lock   = '0;
    bus.m_wvalid = '0;
    bus.m_wlast  = '0;
    bus.m_wdata  = '0;
    bus.m_wmask  = '0;
    bus.m_rready = '0;
    bus.m_eack   = '0;
    bus.s_cready = 1'b0;
    bus.s_wready = 1'b0;
    bus.s_rvalid = 1'b0;
    bus.s_rlast  = 1'b0;
    bus.s_rdata  = '0;
    bus.s_error  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    bus.m_cvalid = 2'b11;
    tick();
    tick();
    #1;
    checks++;
    if (outs !== 14'h0) begin
      failures++;
      $display("FAIL reset_outs: got %0h want 0", outs);
    end
    bus.m_cvalid = '0;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_read();
    bus.m_cvalid = 2'b10;
    bus.m_cmd    = 2'b10;
    bus.m_addr[27 +: 27] = 27'h0400000;
    bus.m_addr[0 +: 27]  = 27'h7ffffff;
    #1;
    checks++;
    if (bus.gnt !== 2'b00 || bus.s_cvalid !== 1'b0) begin
      failures++;
      $display("FAIL read_idle: got gnt=%b s_cvalid=%b want 00/0", bus.gnt, bus.s_cvalid);
    end
    tick();
    #1;
    checks++;
    if (bus.gnt !== 2'b10 || bus.s_cvalid !== 1'b1 || bus.s_cmd !== 1'b1 ||
        bus.s_addr !== 27'h0400000 || bus.m_cready !== 2'b00) begin
      failures++;
      $display("FAIL read_cmd: got gnt=%b cv=%b cmd=%b addr=%h crdy=%b want 10/1/1/0400000/00",
               bus.gnt, bus.s_cvalid, bus.s_cmd, bus.s_addr, bus.m_cready);
    end
    bus.s_cready = 1'b1;
    #1;
    checks++;
    if (bus.m_cready !== 2'b10) begin
      failures++;
      $display("FAIL read_cready: got %b want 10", bus.m_cready);
    end
    tick();
    bus.m_cvalid = '0;
    bus.s_cready = 1'b0;
    bus.s_rvalid = 1'b1;
    bus.s_rdata  = 32'hCAFE_0001;
    bus.s_rlast  = 1'b0;
    bus.m_rready = 2'b10;
    #1;
    checks++;
    if (bus.m_rvalid !== 2'b10 || bus.s_rready !== 1'b1 || bus.m_rdata !== 32'hCAFE_0001 ||
        bus.s_cvalid !== 1'b0) begin
      failures++;
      $display("FAIL read_beat1: got rv=%b rr=%b data=%h cv=%b want 10/1/cafe0001/0",
               bus.m_rvalid, bus.s_rready, bus.m_rdata, bus.s_cvalid);
    end
    tick();
    bus.s_rdata = 32'hCAFE_0002;
    bus.s_rlast = 1'b1;
    #1;
    checks++;
    if (bus.m_rvalid !== 2'b10 || bus.m_rlast !== 1'b1 || bus.gnt !== 2'b10) begin
      failures++;
      $display("FAIL read_beat2: got rv=%b rlast=%b gnt=%b want 10/1/10",
               bus.m_rvalid, bus.m_rlast, bus.gnt);
    end
    tick();
    bus.s_rvalid = 1'b0;
    bus.s_rlast  = 1'b0;
    bus.m_rready = '0;
    #1;
    checks++;
    if (bus.gnt !== 2'b00 || bus.m_rvalid !== 2'b00) begin
      failures++;
      $display("FAIL read_done_idle: got gnt=%b rv=%b want 00/00", bus.gnt, bus.m_rvalid);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_rotation();
    logic [1:0] exp_g [12] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10,
                               2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
    bus.m_cvalid = 2'b11;
    bus.m_cmd    = 2'b11;
    bus.m_rready = 2'b11;
    bus.s_cready = 1'b1;
    bus.s_rvalid = 1'b1;
    bus.s_rlast  = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      checks++;
      if (bus.gnt !== exp_g[c]) begin
        failures++;
        $display("FAIL rotation_gnt[%0d]: got %b want %b", c, bus.gnt, exp_g[c]);
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_write();
    bus.m_cvalid = 2'b10;
    bus.m_cmd    = 2'b00;
    bus.m_addr[27 +: 27]  = 27'h0000123;
    bus.m_wvalid = 2'b10;
    bus.m_wlast  = 2'b00;
    bus.m_wdata[32 +: 32] = 32'hD0D0_0000;
    bus.m_wdata[0 +: 32]  = 32'hBAD0_BAD0;
    bus.m_wmask[4 +: 4]   = 4'hA;
    bus.m_wmask[0 +: 4]   = 4'h5;
    bus.s_cready = 1'b1;
    bus.s_wready = 1'b1;
    #1;
    checks++;
    if (bus.s_wvalid !== 1'b0 || bus.m_wready !== 2'b00) begin
      failures++;
      $display("FAIL write_idle_early: got wv=%b wr=%b want 0/00", bus.s_wvalid, bus.m_wready);
    end
    tick();
    #1;
    checks++;
    if (bus.s_cvalid !== 1'b1 || bus.s_cmd !== 1'b0 || bus.s_addr !== 27'h0000123 ||
        bus.s_wvalid !== 1'b0 || bus.m_wready !== 2'b00) begin
      failures++;
      $display("FAIL write_cmd: got cv=%b cmd=%b addr=%h wv=%b wr=%b want 1/0/0000123/0/00",
               bus.s_cvalid, bus.s_cmd, bus.s_addr, bus.s_wvalid, bus.m_wready);
    end
    tick();
    bus.m_cvalid = '0;
    bus.s_wready = 1'b0;
    #1;
    checks++;
    if (bus.s_wvalid !== 1'b1 || bus.s_wdata !== 32'hD0D0_0000 || bus.m_wready !== 2'b00) begin
      failures++;
      $display("FAIL write_stall1: got wv=%b data=%h wr=%b want 1/d0d00000/00",
               bus.s_wvalid, bus.s_wdata, bus.m_wready);
    end
    tick();
    #1;
    checks++;
    if (bus.m_wready !== 2'b00 || bus.gnt !== 2'b10) begin
      failures++;
      $display("FAIL write_stall2: got wr=%b gnt=%b want 00/10", bus.m_wready, bus.gnt);
    end
    tick();
    bus.s_wready = 1'b1;
    #1;
    checks++;
    if (bus.m_wready !== 2'b10 || bus.s_wdata !== 32'hD0D0_0000) begin
      failures++;
      $display("FAIL write_ready: got wr=%b data=%h want 10/d0d00000", bus.m_wready, bus.s_wdata);
    end
    tick();
    bus.m_wdata[32 +: 32] = 32'hD0D0_0001;
    #1;
    checks++;
    if (bus.gnt !== 2'b10 || bus.s_wlast !== 1'b0) begin
      failures++;
      $display("FAIL write_beat2: got gnt=%b wlast=%b want 10/0", bus.gnt, bus.s_wlast);
    end
    tick();
    bus.m_wdata[32 +: 32] = 32'hD0D0_0002;
    bus.m_wlast = 2'b10;
    #1;
    checks++;
    if (bus.s_wlast !== 1'b1 || bus.s_wmask !== 4'hA || bus.s_wdata !== 32'hD0D0_0002 ||
        bus.gnt !== 2'b10) begin
      failures++;
      $display("FAIL write_beat3: got wlast=%b mask=%h data=%h gnt=%b want 1/a/d0d00002/10",
               bus.s_wlast, bus.s_wmask, bus.s_wdata, bus.gnt);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.gnt !== 2'b00 || bus.s_wvalid !== 1'b0) begin
      failures++;
      $display("FAIL write_done_idle: got gnt=%b wv=%b want 00/0", bus.gnt, bus.s_wvalid);
    end
    tick();
  endtask

  task automatic test_lock();
    logic [1:0] exp_g [11] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00,
                               2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
    bus.m_cvalid = 2'b10;
    bus.m_lock   = 2'b10;
    bus.m_cmd    = 2'b11;
    bus.m_rready = 2'b11;
    bus.s_cready = 1'b1;
    bus.s_rvalid = 1'b1;
    bus.s_rlast  = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c >= 1) bus.m_cvalid = 2'b11;
      #1;
      checks++;
      if (bus.gnt !== exp_g[c]) begin
        failures++;
        $display("FAIL lock_gnt[%0d]: got %b want %b", c, bus.gnt, exp_g[c]);
      end
      tick();
    end
    // m1 is back in CMD on its lock; withdrawing the command releases the bus
    bus.m_cvalid = '0;
    bus.m_lock   = '0;
    #1;
    checks++;
    if (bus.gnt !== 2'b10 || bus.s_cvalid !== 1'b0) begin
      failures++;
      $display("FAIL lock_cont_cmd: got gnt=%b cv=%b want 10/0", bus.gnt, bus.s_cvalid);
    end
    tick();
    #1;
    checks++;
    if (bus.gnt !== 2'b00) begin
      failures++;
      $display("FAIL lock_drop_idle: got gnt=%b want 00", bus.gnt);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_error();
    bus.m_cvalid = 2'b01;
    bus.m_cmd    = 2'b01;
    bus.m_lock   = 2'b01;
    bus.m_rready = 2'b01;
    bus.s_cready = 1'b1;
    tick();
    tick();
    bus.s_error = 1'b1;
    #1;
    checks++;
    if (bus.m_error !== 2'b01 || bus.s_eack !== 1'b0) begin
      failures++;
      $display("FAIL err_raise: got err=%b eack=%b want 01/0", bus.m_error, bus.s_eack);
    end
    tick();
    #1;
    checks++;
    if (bus.m_error !== 2'b01 || bus.gnt !== 2'b01) begin
      failures++;
      $display("FAIL err_hold: got err=%b gnt=%b want 01/01", bus.m_error, bus.gnt);
    end
    bus.m_eack = 2'b01;
    #1;
    checks++;
    if (bus.s_eack !== 1'b1) begin
      failures++;
      $display("FAIL err_eack: got %b want 1", bus.s_eack);
    end
    tick();
    #1;
    checks++;
    if (bus.gnt !== 2'b00 || bus.m_error !== 2'b00) begin
      failures++;
      $display("FAIL err_idle_locked: got gnt=%b err=%b want 00/00", bus.gnt, bus.m_error);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    bus.m_cvalid = 2'b01;
    bus.m_cmd    = 2'b01;
    bus.s_cready = 1'b1;
    tick();
    tick();
    bus.m_cvalid = 2'b11;
    bus.m_cmd    = 2'b11;
    bus.m_rready = 2'b11;
    bus.s_rvalid = 1'b1;
    bus.s_rlast  = 1'b0;
    #1;
    checks++;
    if (bus.m_rvalid !== 2'b01) begin
      failures++;
      $display("FAIL rstmid_pre: got rv=%b want 01", bus.m_rvalid);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    checks++;
    if (outs !== 14'h0) begin
      failures++;
      $display("FAIL rstmid_outs: got %0h want 0", outs);
    end
    tick();
    #1;
    checks++;
    if (bus.gnt !== 2'b01) begin
      failures++;
      $display("FAIL rstmid_regrant: got %b want 01", bus.gnt);
    end
    clear_inputs();
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    clear_inputs();
    test_reset();
    test_basic_read();
    test_rotation();
    test_write();
    test_lock();
    test_error();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
